// File: rtl/mic_fft_frame_scheduler_pkg.sv
// mic_fft_pkg: shared defaults and FSM state types for the mic-to-FFT frame scheduler.
package mic_fft_pkg;
  localparam int DEF_SAMPLE_W = 18;
  localparam int DEF_FRAME_LEN = 256;
  typedef enum logic {FILL, WAIT} wr_state_e;
  typedef enum logic [1:0] {IDLE, FETCH, STREAM} rd_state_e;
endpackage

// File: rtl/mic_fft_frame_scheduler_if.sv
// mic_fft_frame_scheduler_if: framed valid/ready sample stream toward the FFT.
interface mic_fft_frame_scheduler_if #(parameter int SAMPLE_W = 18);
  logic                fft_valid;
  logic [SAMPLE_W-1:0] fft_data;
  logic                fft_sop;
  logic                fft_eop;
  logic                fft_ready;
  modport master (output fft_valid, fft_data, fft_sop, fft_eop, input fft_ready);
  modport slave (input fft_valid, fft_data, fft_sop, fft_eop, output fft_ready);
endinterface

// File: rtl/mic_fft_frame_scheduler_frame_bank_ram.sv
// frame_bank_ram: simple dual-port sample store, address {bank, idx}, 1-cycle read latency.
module frame_bank_ram #(
  parameter int W  = 18,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/mic_fft_frame_scheduler.sv
// mic_fft_frame_scheduler: ping-pong frame capture of mic samples streamed to the FFT with frame-aligned overflow drop.
// MIC_FFT_DROP_CNT_EN adds a saturating drop_count output and its drop_count_clr input.
module mic_fft_frame_scheduler
  import mic_fft_pkg::*;
#(
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  localparam int IDX_W    = $clog2(FRAME_LEN)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                new_t,
  input  logic [SAMPLE_W-1:0] t,
  mic_fft_frame_scheduler_if.master fft,
  output logic                sample_dropped,
`ifdef MIC_FFT_DROP_CNT_EN
  output logic [15:0]         drop_count,
  input  logic                drop_count_clr,
`endif
  output logic                busy
);
  wr_state_e           ws_q, ws_d;
  rd_state_e           rs_q, rs_d;
  logic                wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]    wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [1:0]          full_q, full_d, set, clr;
  logic [SAMPLE_W-1:0] data_q, data_d, ram_q;
  logic                we, hs, last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ws_q      <= FILL;
      rs_q      <= IDLE;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      full_q    <= '0;
      data_q    <= '0;
    end else begin
      ws_q      <= ws_d;
      rs_q      <= rs_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      full_q    <= full_d;
      data_q    <= data_d;
    end
  end

  // A strobe seen while the target bank is still full is dropped, never written.
  always_comb begin
    ws_d           = ws_q;
    wr_bank_d      = wr_bank_q;
    wr_idx_d       = wr_idx_q;
    we             = 1'b0;
    set            = '0;
    sample_dropped = 1'b0;
    if (ws_q == WAIT) begin
      sample_dropped = new_t && enable;
      ws_d           = full_q[wr_bank_q] ? WAIT : FILL;
    end else if (full_q[wr_bank_q]) begin
      sample_dropped = new_t && enable;
      ws_d           = WAIT;
    end else if (new_t && enable) begin
      we       = 1'b1;
      wr_idx_d = wr_idx_q + 1'b1;
      if (wr_idx_q == IDX_W'(FRAME_LEN - 1)) begin
        set[wr_bank_q] = 1'b1;
        wr_bank_d      = ~wr_bank_q;
      end
    end
    if (!enable) wr_idx_d = '0;
  end

  assign hs   = (rs_q == STREAM) && fft.fft_ready;
  assign last = rd_idx_q == IDX_W'(FRAME_LEN - 1);

  always_comb begin
    rs_d      = rs_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    data_d    = data_q;
    clr       = '0;
    if (rs_q == IDLE && full_q[rd_bank_q]) rs_d = FETCH;
    if (rs_q == FETCH) begin
      rs_d   = STREAM;
      data_d = ram_q;
    end
    if (hs) begin
      rs_d     = last ? IDLE : FETCH;
      rd_idx_d = rd_idx_q + 1'b1;
      if (last) begin
        clr[rd_bank_q] = 1'b1;
        rd_bank_d      = ~rd_bank_q;
      end
    end
  end

  assign full_d = (full_q | set) & ~clr;

  // Read address follows next-state so the RAM output is ready during FETCH.
  frame_bank_ram #(.W(SAMPLE_W), .AW(IDX_W + 1)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr ({wr_bank_q, wr_idx_q}),
    .wdata (t),
    .raddr ({rd_bank_d, rd_idx_d}),
    .rdata (ram_q)
  );

  assign fft.fft_valid = rs_q == STREAM;
  assign fft.fft_data  = data_q;
  assign fft.fft_sop   = (rs_q == STREAM) && (rd_idx_q == '0);
  assign fft.fft_eop   = (rs_q == STREAM) && last;
  assign busy          = (|full_q) || (rs_q != IDLE);

`ifdef MIC_FFT_DROP_CNT_EN
  logic [15:0] drop_count_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_count_q <= '0;
    else if (drop_count_clr) drop_count_q <= '0;
    else if (sample_dropped && drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
  end
  assign drop_count = drop_count_q;
`endif
endmodule

// File: doc/mic_fft_frame_scheduler.md
Name: mic_fft_frame_scheduler

Overview:
- Sits between the I2S mic sample translator and the FFT processor.
- Collects the 18-bit two's-complement mic samples (new_t/t strobe) into ping-pong frame banks.
- Streams each complete frame to the FFT input with sop/eop framing and valid/ready backpressure.
- Owns the policy for overflow: when both banks are occupied, whole-frame-aligned dropping is applied.

Parameters:
- SAMPLE_W, 18, sample width in bits (two's complement).
- FRAME_LEN, 256, samples per frame; must be a power of two and at least 4.
- IDX_W, $clog2(FRAME_LEN), sample index width (derived, not overridden).

Ports:
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable.
- new_t  in  1  one-cycle sample strobe from the mic translator.
- t  in  SAMPLE_W  sample value; valid only while new_t=1.
- fft_valid  out  1  output sample valid.
- fft_data  out  SAMPLE_W  output sample.
- fft_sop  out  1  first sample of a frame; qualified by fft_valid.
- fft_eop  out  1  last sample of a frame; qualified by fft_valid.
- fft_ready  in  1  FFT accepts a sample when fft_valid&&fft_ready.
- sample_dropped  out  1  one-cycle pulse per discarded sample.
- busy  out  1  high while any bank is full or the read FSM is not in IDLE.

Behaviour:
- Reset: clk is the only clock; reset is asynchronous and active-low. While reset=0, all of the following hold:
  - Outputs: fft_valid, fft_sop, fft_eop, sample_dropped and busy are 0; fft_data is 0.
  - Write side: wr_bank=0, wr_idx=0, write state is FILL.
  - Bank state: full[1:0]=0.
  - Read side: rd_bank=0, rd_idx=0, read state is IDLE.
  - Reset mid-frame abandons all buffered data; there is no partial output.
- Storage: 2 banks x FRAME_LEN x SAMPLE_W. Writes are synchronous. Reads are synchronous with 1-cycle latency.
- Write FSM, states FILL and WAIT:
  - FILL: on new_t&&enable, write t to [wr_bank][wr_idx] and increment wr_idx.
  - At wr_idx==FRAME_LEN-1, the write sets full[wr_bank], toggles wr_bank and wraps wr_idx to 0.
  - FILL -> WAIT when the bank just selected (new wr_bank) has full=1, evaluated on the cycle after the toggle.
  - WAIT: every new_t produces sample_dropped=1 for 1 cycle; no write occurs.
  - WAIT -> FILL when full[wr_bank]=0. The first sample written after leaving WAIT goes to index 0 (frame-aligned).
  - enable=0: new_t is ignored with no drop pulse, and wr_idx is forced to 0, so a partial frame is discarded. full bits and the read side are unaffected.
- Read FSM, states IDLE, FETCH and STREAM:
  - IDLE: if full[rd_bank], go to FETCH and issue read of [rd_bank][rd_idx].
  - FETCH (1 cycle): fft_valid=0. Next state is STREAM, with fft_data = RAM output registered.
  - STREAM: fft_valid=1, fft_sop=(rd_idx==0), fft_eop=(rd_idx==FRAME_LEN-1).
  - fft_data, sop and eop are held stable while fft_valid&&!fft_ready.
  - On handshake, not last sample: increment rd_idx and go to FETCH.
  - On handshake, last sample: clear full[rd_bank], toggle rd_bank, rd_idx=0, go to IDLE.
  - Maximum throughput is 1 sample per 2 cycles. This is sufficient because the mic produces 1 sample per 64 BCLK.
- Latency: if the last sample of a frame is written at edge E, full is set at E. IDLE sees it at E+1 (FETCH). fft_valid rises after edge E+2.
- Simultaneous events:
  - The read side clears full[b] while the writer is in WAIT on b in the same cycle: the clear wins, and the writer leaves WAIT on the next cycle. A new_t in the clear cycle is still dropped.
  - The writer setting full on one bank while the reader clears the other never conflicts; each full bit has a single set source and a single clear source.
- Width rule: samples pass through bit-exact, with no arithmetic.

Optional Feature:
- Macro: MIC_FFT_DROP_CNT_EN.
- Defined:
  - Adds output drop_count, out, 16 bits, resetting to 0.
  - drop_count increments on each sample_dropped pulse and saturates at 16'hFFFF.
  - Adds input drop_count_clr, in, 1: synchronous clear with priority over increment.
- Undefined: neither port exists. sample_dropped is unchanged.

Decomposition:
- Package mic_fft_pkg: SAMPLE_W default, FRAME_LEN default, write-state enum {FILL, WAIT}, read-state enum {IDLE, FETCH, STREAM}.
- Sub-module frame_bank_ram:
  - Simple dual-port, depth 2*FRAME_LEN, address {bank, idx}.
  - One synchronous write port and one synchronous read port with 1-cycle latency.

Test Plan (FRAME_LEN=8):
- Basic frame:
  - Stimulus: enable=1, fft_ready=1; 8 strobes t=1..8, spaced 4 cycles apart.
  - Required response: fft_valid rises 2 cycles after the 8th write; data 1..8 appears with sop on 1 and eop on 8; busy returns to 0.
- Backpressure:
  - Stimulus: fft_ready=0 for 10 cycles during STREAM at sample 3.
  - Required response: fft_data=3, fft_valid=1 held stable; the stream resumes in order after fft_ready=1.
- Overflow:
  - Stimulus: fft_ready=0 permanently; 20 strobes.
  - Required response: samples 1-16 stored; samples 17-20 each give a sample_dropped pulse. After fft_ready=1, two frames are output (1..8, then 9..16).
- Alignment after WAIT:
  - Stimulus: continue the overflow case; release fft_ready, then send t=100..107.
  - Required response: the third frame is exactly 100..107, with sop on 100.
- enable drop:
  - Stimulus: 5 strobes, enable=0, enable=1, then 8 strobes t=50..57.
  - Required response: output is the single frame 50..57, and sample_dropped never pulses.
- Async reset:
  - Stimulus: assert reset mid-STREAM.
  - Required response: fft_valid=0 immediately, without waiting for a clock edge; after release, the next complete frame is output correctly. With MIC_FFT_DROP_CNT_EN, drop_count=0 after reset and =4 after the overflow case.
